// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Bit-serial WIDTH-bit adder. One 1-bit full-adder slice is formed from two
// half adders and an OR gate. The slice runs LSB-first for WIDTH cycles and
// keeps the running carry in a register between cycles.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Ready never depends on valid. A producer holds valid (and its
// data) until the transfer edge.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands a/b valid
//   in_ready   controller can accept operands (IDLE only)
//   a, b       WIDTH-bit operands, sampled on the accept edge
//   busy       operation in progress or result pending (RUN, DONE)
//   out_valid  sum/cout hold a completed result (DONE only)
//   out_ready  consumer takes the result
//   sum        WIDTH-bit registered sum
//   cout       registered carry-out of the MSB
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Bit counter is clog2(WIDTH) wide, but never narrower than one bit.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Full-adder slice: two half adders plus an OR for the carry.
  logic p, g1, s, g2, carry_next;

  always_comb begin
    // Half adder 1 on the operand LSBs.
    p          = a_q[0] ^ b_q[0];
    g1         = a_q[0] & b_q[0];
    // Half adder 2 folds in the stored carry.
    s          = p ^ carry_q;
    g2         = p & carry_q;
    carry_next = g1 | g2;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sum_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the
        // result has reached sum[0]. Written as shifts so WIDTH=1 works.
        sum_d   = (sum_q >> 1) | (WIDTH'(s) << (WIDTH - 1));
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          cout_d  = carry_next;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are decoded from registered state only.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
